// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner selection for a shared 8:1 single-bit mux: drives the
// registered one-hot grant plus the matching select code, with a burst limit.
module mux8_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] sel,
    output logic       busy,
    output logic [7:0] hold_cnt
);

    // state | meaning
    // IDLE  | no owner; grant is zero, sel keeps the last owner index
    // OWN   | owner_q holds the grant; hold_cnt counts its tenure
    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam logic       HOLD_LIMITED = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST    = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] owner_q, owner_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [7:0] hold_left_q, hold_left_d;

    logic [2:0] scan_ptr;
    logic [2:0] cand;
    logic [2:0] win_idx;
    logic       win_vld;
    logic       timeout;
    logic       release_own;
    logic       take_grant;

    // On release the scan starts just past the outgoing owner, so the new
    // pointer is applied in the same edge as the handoff.
    assign scan_ptr = (state_q == OWN) ? 3'(owner_q + 3'd1) : ptr_q;

    // Reverse scan: the last hit written is the one closest to scan_ptr.
    always_comb begin
        win_vld = 1'b0;
        win_idx = 3'd0;
        cand    = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            cand = 3'(scan_ptr + 3'(k));
            if (req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Burst limit is a down-counter reloaded on each grant; terminal count is zero.
    assign timeout     = HOLD_LIMITED && (hold_left_q == 8'd0);
    assign release_own = !req[owner_q] || timeout;
    assign take_grant  = en && win_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 3'd0;
            owner_q     <= 3'd0;
            grant_q     <= 8'h00;
            sel_q       <= 3'd0;
            hold_cnt_q  <= 8'd0;
            hold_left_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            grant_q     <= grant_d;
            sel_q       <= sel_d;
            hold_cnt_q  <= hold_cnt_d;
            hold_left_q <= hold_left_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (take_grant) begin
                    state_d = OWN;
                end
            end
            OWN: begin
                if (release_own && !take_grant) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        grant_d     = grant_q;
        sel_d       = sel_q;
        hold_cnt_d  = hold_cnt_q;
        hold_left_d = hold_left_q;
        case (state_q)
            IDLE: begin
                if (take_grant) begin
                    owner_d     = win_idx;
                    grant_d     = 8'(8'h01 << win_idx);
                    sel_d       = win_idx;
                    hold_cnt_d  = 8'd0;
                    hold_left_d = HOLD_LAST;
                end
            end
            OWN: begin
                if (release_own) begin
                    ptr_d = scan_ptr;
                    if (take_grant) begin
                        owner_d     = win_idx;
                        grant_d     = 8'(8'h01 << win_idx);
                        sel_d       = win_idx;
                        hold_cnt_d  = 8'd0;
                        hold_left_d = HOLD_LAST;
                    end else begin
                        grant_d     = 8'h00;
                        hold_cnt_d  = 8'd0;
                        hold_left_d = 8'd0;
                    end
                end else begin
                    if (hold_cnt_q != 8'hFF) begin
                        hold_cnt_d = hold_cnt_q + 8'd1;
                    end
                    if (hold_left_q != 8'd0) begin
                        hold_left_d = hold_left_q - 8'd1;
                    end
                end
            end
            default: begin
                grant_d    = 8'h00;
                hold_cnt_d = 8'd0;
            end
        endcase
    end

    assign grant    = grant_q;
    assign sel      = sel_q;
    assign busy     = |grant_q;
    assign hold_cnt = hold_cnt_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: two instances (burst limits 8 and 4)
// share stimulus; expected values are hand-computed per scenario.
module tb_mux8_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;

    logic [7:0] grant8, hold8, grant4, hold4;
    logic [2:0] sel8, sel4;
    logic       busy8, busy4;

    int n_tests = 0;
    int n_fail  = 0;

    mux8_rr_arbiter #(.MAX_HOLD(8)) u_dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .req      (req),
        .grant    (grant8),
        .sel      (sel8),
        .busy     (busy8),
        .hold_cnt (hold8)
    );

    mux8_rr_arbiter #(.MAX_HOLD(4)) u_dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .req      (req),
        .grant    (grant4),
        .sel      (sel4),
        .busy     (busy4),
        .hold_cnt (hold4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        req   = 8'h00;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        req   = 8'h00;

        // Idle after reset
        do_reset();
        check("rst_grant", 32'(grant8), 32'h00);
        check("rst_sel",   32'(sel8),   32'd0);
        check("rst_busy",  32'(busy8),  32'd0);
        check("rst_hold",  32'(hold8),  32'd0);
        for (int c = 0; c < 5; c++) begin
            step();
            check("idle_grant", 32'(grant8), 32'h00);
            check("idle_busy",  32'(busy8),  32'd0);
            check("idle_sel",   32'(sel8),   32'd0);
            check("idle_hold",  32'(hold8),  32'd0);
        end

        // Single requester 2 for three cycles, then drop
        req = 8'b0000_0100;
        for (int c = 0; c < 3; c++) begin
            step();
            check("r2_grant", 32'(grant8), 32'h04);
            check("r2_sel",   32'(sel8),   32'd2);
            check("r2_hold",  32'(hold8),  32'(c));
            check("r2_busy",  32'(busy8),  32'd1);
        end
        req = 8'h00;
        step();
        check("r2_drop_grant", 32'(grant8), 32'h00);
        check("r2_drop_busy",  32'(busy8),  32'd0);
        check("r2_drop_sel",   32'(sel8),   32'd2);
        check("r2_drop_hold",  32'(hold8),  32'd0);

        // All requesting, burst 8: rotation 0..7 then back to 0
        do_reset();
        req = 8'hFF;
        for (int c = 0; c < 65; c++) begin
            step();
            check("rot_grant", 32'(grant8), 32'(8'h01 << ((c / 8) % 8)));
            check("rot_sel",   32'(sel8),   32'((c / 8) % 8));
            check("rot_hold",  32'(hold8),  32'(c % 8));
            check("rot_busy",  32'(busy8),  32'd1);
        end

        // Lone requester 5, burst 4: re-granted with no idle cycle
        do_reset();
        req = 8'h20;
        for (int c = 0; c < 12; c++) begin
            step();
            check("h4_grant", 32'(grant4), 32'h20);
            check("h4_sel",   32'(sel4),   32'd5);
            check("h4_hold",  32'(hold4),  32'(c % 4));
            check("h4_busy",  32'(busy4),  32'd1);
        end

        // Owner 3 with 6 and 1 pending: handoff order 6 then 1
        do_reset();
        req = 8'h08;
        step();
        check("o3_grant", 32'(grant8), 32'h08);
        req = 8'h4A;
        step();
        step();
        check("o3_hold_grant", 32'(grant8), 32'h08);
        check("o3_hold_cnt",   32'(hold8),  32'd2);
        req = 8'h42;
        step();
        check("o6_grant", 32'(grant8), 32'h40);
        check("o6_sel",   32'(sel8),   32'd6);
        check("o6_hold",  32'(hold8),  32'd0);
        req = 8'h02;
        step();
        check("o1_grant", 32'(grant8), 32'h02);
        check("o1_sel",   32'(sel8),   32'd1);
        check("o1_busy",  32'(busy8),  32'd1);

        // en=0 blocks a new grant; existing owner ignores en
        do_reset();
        en  = 1'b0;
        req = 8'h10;
        for (int c = 0; c < 3; c++) begin
            step();
            check("en0_grant", 32'(grant8), 32'h00);
            check("en0_busy",  32'(busy8),  32'd0);
        end
        en = 1'b1;
        step();
        check("en1_grant", 32'(grant8), 32'h10);
        check("en1_sel",   32'(sel8),   32'd4);
        en = 1'b0;
        step();
        check("en0_own_grant", 32'(grant8), 32'h10);
        check("en0_own_hold",  32'(hold8),  32'd1);
        en = 1'b1;

        // Asynchronous reset mid-grant, then restart from requester 0
        do_reset();
        req = 8'hFF;
        for (int c = 0; c < 10; c++) step();
        check("pre_rst_grant", 32'(grant8), 32'h02);
        check("pre_rst_hold",  32'(hold8),  32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_grant", 32'(grant8), 32'h00);
        check("arst_sel",   32'(sel8),   32'd0);
        check("arst_busy",  32'(busy8),  32'd0);
        check("arst_hold",  32'(hold8),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_grant", 32'(grant8), 32'h01);
        check("post_rst_sel",   32'(sel8),   32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter that shares one 8-to-1 single-bit mux between eight requesters.
- Drives the mux select code (B2..B0 = sel[2:0]) and a one-hot grant vector, so exactly one requester's data reaches the mux output at a time.
- Grants are held while the owner keeps requesting, up to a configurable burst limit.
- Sits between the requesting units and the datapath mux.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the grant. Range 1..255; 0 = unlimited.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  arbitration enable; 0 blocks new grants, and an existing grant continues
- req  input  8  request vector, bit i = requester i
- grant  output  8  one-hot grant, registered; all-zero when no owner
- sel  output  3  mux select code {B2,B1,B0} = index of current or last owner, registered
- busy  output  1  1 while a grant is active (equals |grant)
- hold_cnt  output  8  cycles the current owner has held the grant, 0-based

Behaviour:
- Reset (async, rst_n=0): grant=8'h00, sel=3'd0, busy=0, hold_cnt=0, state=IDLE, priority pointer ptr=3'd0.
- Reset takes effect immediately mid-grant; the first grant after release needs a clk edge with rst_n=1.
- States: IDLE (no owner) and OWN (one owner held in register owner[2:0]).
- Arbitration function: first set bit of req scanning ptr, ptr+1, ..., ptr+7 (mod 8). Purely combinational from registered ptr and live req.
- IDLE -> OWN: at a clk edge with en=1 and req!=0:
  - owner=winner, grant=1<<winner, sel=winner, busy=1, hold_cnt=0.
  - Latency: req seen at edge N gives grant visible after edge N (one-cycle registered latency).
- IDLE with en=0 or req=0: stays IDLE; sel keeps its last value so the mux input does not change.
- OWN, release condition R = (req[owner]==0) OR (MAX_HOLD!=0 AND hold_cnt==MAX_HOLD-1).
- OWN, R=0: stay OWN, hold_cnt+=1 (saturate at 255 when MAX_HOLD=0); grant and sel unchanged. en is ignored for an existing owner.
- OWN, R=1: ptr=owner+1 (mod 8), then rearbitrate in the same edge using the new ptr and current req.
  - If en=1 and a winner exists: back-to-back handoff with no idle cycle. grant/sel switch to the new winner and hold_cnt=0.
  - A timed-out owner still requesting is re-granted only if no other requester is active (scan wraps to it last).
  - Otherwise: go to IDLE, grant=0, busy=0, hold_cnt=0, sel unchanged.
- grant is always one-hot or zero. sel == index of the set grant bit whenever busy=1.
- Simultaneous requests are resolved purely by ptr order, so no requester waits more than 7 grant tenures.
- MAX_HOLD=1: every grant lasts exactly one cycle, giving strict rotation among active requesters.
- req changes while in OWN do not affect grant until R=1.
- X on req is not permitted; the bench must drive known values.

Test Plan:
- Reset, then req=8'h00 for 5 cycles -> grant=0, busy=0, sel=0, hold_cnt=0 throughout.
- req=8'b0000_0100 held for 3 cycles, then dropped:
  - grant=8'h04 and sel=2 from the edge after req rises, with hold_cnt counting 0,1,2.
  - grant=0 one edge after the drop; sel stays 2.
- MAX_HOLD=8, req=8'hFF constant:
  - grants rotate 0,1,2,...,7,0, each held exactly 8 cycles.
  - handoffs are back-to-back with busy never dropping.
  - sel follows 0..7.
- MAX_HOLD=4, only req[5]=1 continuously -> grant stays 8'h20, and hold_cnt wraps 0..3 then restarts at 0 (re-grant, no idle cycle).
- Owner 3 active while req[6] and req[1] are also pending; owner drops req[3] -> next grant is 6 (ptr=4 scan), then after 6 releases, grant 1.
- en=0 with req=8'h10 -> no grant. en=1 -> grant=8'h10 next edge.
- Assert rst_n=0 asynchronously mid-grant -> grant=0, sel=0, busy=0 immediately; after release, req=8'hFF grants requester 0 first.
